// File: rtl/d_debounce_edge.sv
// Synchronizes and debounces a noisy single-bit D into a clean level Q, with rise/fall pulses
// and a wrapping edge counter. Define D_DEBOUNCE_EDGE_BOTH_EN to count falling transitions too.
module d_debounce_edge #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             D,
  input  logic             clr_cnt,
  output logic             Q,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             cnt_ovf
);

  localparam logic [7:0] STAB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [7:0]             stab;
  logic                   sync_q;
  logic                   differ;
  logic                   flip;
  logic                   cnt_inc;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= '0;
    else        sync <= {sync[SYNC_STAGES-2:0], D};

  assign sync_q = sync[SYNC_STAGES-1];
  assign differ = sync_q != Q;
  // Q commits on the cycle the mismatch has persisted DEBOUNCE_CYCLES times in a row.
  assign flip   = differ && (stab == STAB_LAST);

`ifdef D_DEBOUNCE_EDGE_BOTH_EN
  assign cnt_inc = flip;
`else
  assign cnt_inc = flip && sync_q;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stab <= '0;
      Q    <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= flip && sync_q;
      fall <= flip && !sync_q;
      if (!differ) stab <= '0;
      else if (flip) begin
        stab <= '0;
        Q    <= sync_q;
      end else stab <= stab + 8'd1;
    end

  // Clear wins over a coincident increment; the overflow flag is sticky until cleared.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      edge_cnt <= '0;
      cnt_ovf  <= 1'b0;
    end else if (clr_cnt) begin
      edge_cnt <= '0;
      cnt_ovf  <= 1'b0;
    end else if (cnt_inc) begin
      edge_cnt <= edge_cnt + CNT_W'(1);
      if (&edge_cnt) cnt_ovf <= 1'b1;
    end

endmodule

// File: tb/tb_d_debounce_edge.sv
// Directed bench for d_debounce_edge at default parameters: cycle-stamped expectations are
// queued as stimulus is driven and compared when the monitor reaches that cycle.
module tb_d_debounce_edge;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       D = 1'b0;
  logic       clr_cnt = 1'b0;
  logic       Q, rise, fall, cnt_ovf;
  logic [7:0] edge_cnt;

  d_debounce_edge #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .D(D), .clr_cnt(clr_cnt),
    .Q(Q), .rise(rise), .fall(fall), .edge_cnt(edge_cnt), .cnt_ovf(cnt_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      tag;
    logic [11:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   n_pass = 0, n_total = 0, n_fail = 0;
  int   n_rise = 0, n_fall = 0, n_both = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] x);
    n_total++;
    assert (o === x) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, o, x);
    end
  endtask

  // packed as {Q, rise, fall, edge_cnt, cnt_ovf}
  task automatic expect_at(input int dc, input string tag, input logic q, input logic r,
                           input logic f, input logic [7:0] c, input logic o);
    exp_t t;
    t.cyc = cyc + dc;
    t.tag = tag;
    t.val = {q, r, f, c, o};
    sb.push_back(t);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    D = 1'b1; tick(8);
    D = 1'b0; tick(8);
  endtask

  always @(negedge clk) begin
    if (rise && fall) n_both++;
    if (rise) n_rise++;
    if (fall) n_fall++;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      chk(e.tag, {20'd0, Q, rise, fall, edge_cnt, cnt_ovf}, {20'd0, e.val});
    end
  end

  initial begin
    // reset held while D toggles
    tick(1);
    for (int i = 0; i < 10; i++) begin
      D = ~D;
      expect_at(1, "reset_hold", 0, 0, 0, 8'd0, 0);
      tick(1);
    end
    D = 1'b0; tick(3);
    rst_n = 1'b1; tick(4);

    // clean rise then fall
    D = 1'b1;
    expect_at(5, "rise_pre", 0, 0, 0, 8'd0, 0);
    expect_at(6, "rise_edge", 1, 1, 0, 8'd1, 0);
    expect_at(7, "rise_post", 1, 0, 0, 8'd1, 0);
    tick(10);
    D = 1'b0;
    expect_at(5, "fall_pre", 1, 0, 0, 8'd1, 0);
    expect_at(6, "fall_edge", 0, 0, 1, 8'd1, 0);
    expect_at(7, "fall_post", 0, 0, 0, 8'd1, 0);
    tick(10);

    // 3-cycle glitch is filtered
    D = 1'b1;
    expect_at(6, "glitch3_a", 0, 0, 0, 8'd1, 0);
    expect_at(7, "glitch3_b", 0, 0, 0, 8'd1, 0);
    expect_at(9, "glitch3_c", 0, 0, 0, 8'd1, 0);
    tick(3);
    D = 1'b0;
    tick(10);

    // 4-cycle pulse passes
    D = 1'b1;
    expect_at(5, "glitch4_pre", 0, 0, 0, 8'd1, 0);
    expect_at(6, "glitch4_rise", 1, 1, 0, 8'd2, 0);
    expect_at(10, "glitch4_fall", 0, 0, 1, 8'd2, 0);
    expect_at(11, "glitch4_post", 0, 0, 0, 8'd2, 0);
    tick(4);
    D = 1'b0;
    tick(12);

    // clear then 256 rises -> wrap
    clr_cnt = 1'b1;
    expect_at(1, "clr_pre_wrap", 0, 0, 0, 8'd0, 0);
    tick(1);
    clr_cnt = 1'b0;
    tick(2);
    for (int i = 0; i < 255; i++) pulse();
    expect_at(1, "cnt_255", 0, 0, 0, 8'd255, 0);
    tick(2);
    pulse();
    expect_at(1, "wrap", 0, 0, 0, 8'd0, 1);
    tick(2);
    expect_at(1, "ovf_sticky", 0, 0, 0, 8'd0, 1);
    tick(2);
    clr_cnt = 1'b1;
    expect_at(1, "clr_ovf", 0, 0, 0, 8'd0, 0);
    tick(1);
    clr_cnt = 1'b0;
    tick(2);

    // clear colliding with a rise at edge_cnt=5
    for (int i = 0; i < 5; i++) pulse();
    expect_at(1, "cnt_5", 0, 0, 0, 8'd5, 0);
    tick(2);
    D = 1'b1;
    expect_at(6, "clr_collide", 1, 1, 0, 8'd0, 0);
    expect_at(7, "clr_collide_post", 1, 0, 0, 8'd0, 0);
    tick(5);
    clr_cnt = 1'b1;
    tick(1);
    clr_cnt = 1'b0;
    tick(2);
    D = 1'b0;
    tick(10);

    // reset in the middle of a debounce
    pulse();
    expect_at(1, "pre_rst_cnt", 0, 0, 0, 8'd1, 0);
    tick(2);
    D = 1'b1;
    tick(4);
    rst_n = 1'b0;
    #1;
    chk("async_rst_Q", {31'd0, Q}, 32'd0);
    chk("async_rst_pulses", {30'd0, rise, fall}, 32'd0);
    chk("async_rst_cnt", {24'd0, edge_cnt}, 32'd0);
    chk("async_rst_ovf", {31'd0, cnt_ovf}, 32'd0);
    expect_at(1, "rst_held", 0, 0, 0, 8'd0, 0);
    tick(2);
    rst_n = 1'b1;
    expect_at(5, "rel_pre", 0, 0, 0, 8'd0, 0);
    expect_at(6, "rel_rise", 1, 1, 0, 8'd1, 0);
    expect_at(7, "rel_post", 1, 0, 0, 8'd1, 0);
    tick(10);

    for (int i = 0; i < 50 && sb.size() != 0; i++) tick(1);
    chk("sb_drained", sb.size(), 32'd0);
    chk("rise_total", n_rise, 32'd266);
    chk("fall_total", n_fall, 32'd265);
    chk("rise_fall_overlap", n_both, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
